// File: rtl/plab4_net_ring_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : plab4_net_ring_switch_ctrl
// Brief  : Ring-router switch controller: routing, round-robin arbitration,
//          credit flow control and bubble-based injection control.
// Rev    : 1.0
// ============================================================================
module plab4_net_ring_switch_ctrl #(
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 8,
    parameter int p_num_credits   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   in_val,
    input  logic [3*p_srcdest_nbits-1:0] in_dest,
    output logic [2:0]                   in_rdy,
    output logic [2:0]                   out_val,
    input  logic                         out1_rdy,
    input  logic [1:0]                   credit_ret,
    output logic [5:0]                   out_sel,
    output logic                         credit_err
);

    localparam int c_S  = p_srcdest_nbits;
    localparam int c_DW = p_srcdest_nbits + 2;
    localparam int c_CW = $clog2(p_num_credits + 1);

    localparam logic [c_DW-1:0] c_N    = c_DW'(p_num_routers);
    localparam logic [c_DW-1:0] c_ID   = c_DW'(p_router_id);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(p_num_credits);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_TWO  = c_CW'(2);

    logic [1:0]      r_ptr [3];
    logic [c_CW-1:0] r_credits [2];
    logic            r_credit_err;

    logic [1:0] w_route [3];
    logic [2:0] w_elig  [3];
    logic [1:0] w_gnt   [3];
    logic [2:0] w_any;
    logic [2:0] w_rdy_int;
    logic [2:0] w_xfer;

    // Shortest-path direction; a tie (d == N-d) goes forward.
    function automatic logic [1:0] f_route(input logic [c_S-1:0] dest);
        logic [c_DW-1:0] d;
        d = {2'b00, dest} + c_N - c_ID;
        if (d >= c_N) d = d - c_N;
        if (d == '0)                          return 2'd1;
        else if ({d[c_DW-2:0], 1'b0} > c_N)   return 2'd0;
        else                                  return 2'd2;
    endfunction

    function automatic logic [1:0] f_rot(input logic [1:0] p, input int k);
        logic [2:0] s;
        s = {1'b0, p} + 3'(k);
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_route[i] = f_route(in_dest[i*c_S +: c_S]);
        end
    end

    // Injection needs two credits so one slot is always left for through traffic.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                if (o == 1)
                    w_elig[o][i] = in_val[i] && (w_route[i] == 2'd1);
                else if (i == 1)
                    w_elig[o][i] = in_val[i] && (w_route[i] == 2'(o))
                                   && (r_credits[o/2] >= c_TWO);
                else
                    w_elig[o][i] = in_val[i] && (w_route[i] == 2'(o))
                                   && (r_credits[o/2] >= c_ONE);
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            w_gnt[o] = 2'd0;
            w_any[o] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!w_any[o] && w_elig[o][f_rot(r_ptr[o], k)]) begin
                    w_gnt[o] = f_rot(r_ptr[o], k);
                    w_any[o] = 1'b1;
                end
            end
        end
    end

    assign w_rdy_int = {1'b1, out1_rdy, 1'b1};

    always_comb begin
        out_val = reset ? w_any : 3'b000;
        w_xfer  = out_val & w_rdy_int;
        for (int o = 0; o < 3; o++) begin
            out_sel[2*o +: 2] = out_val[o] ? w_gnt[o] : 2'b11;
        end
        for (int i = 0; i < 3; i++) begin
            in_rdy[i] = reset && w_any[w_route[i]]
                        && (w_gnt[w_route[i]] == 2'(i))
                        && w_rdy_int[w_route[i]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < 3; o++) r_ptr[o] <= 2'd0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (w_xfer[o]) r_ptr[o] <= (w_gnt[o] == 2'd2) ? 2'd0 : w_gnt[o] + 2'd1;
            end
        end
    end

    // Simultaneous transfer and return cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits[0] <= c_FULL;
            r_credits[1] <= c_FULL;
            r_credit_err <= 1'b0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (w_xfer[2*j] && !credit_ret[j]) begin
                    r_credits[j] <= r_credits[j] - c_ONE;
                end else if (!w_xfer[2*j] && credit_ret[j]) begin
                    if (r_credits[j] == c_FULL) r_credit_err <= 1'b1;
                    else                        r_credits[j] <= r_credits[j] + c_ONE;
                end
            end
        end
    end

    assign credit_err = r_credit_err;

endmodule
`default_nettype wire
